// File: rtl/hash_link_pkg.sv
// Constants and state encodings shared by the UART receiver, the hash loader
// and the MD5 generator's serial link.
package hash_link_pkg;

  localparam logic [7:0] SYNC_BYTE            = 8'hA5;
  localparam int         HASH_BYTES           = 16;
  localparam int         DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_HASH,
    F_SUM
  } frame_state_t;

endpackage

// File: rtl/usart_rx.sv
// 8N1 UART receiver with a two-flop input synchroniser; produces one-cycle
// byte_valid / byte_err strobes at the stop-bit sample.
module usart_rx
  import hash_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_led,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_q, rx_s_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_err_q, byte_err_d;

  // Synchroniser presets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= R_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (!rx_s_q) begin
          state_d   = R_START;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = R_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d        = '0;
          byte_valid_d = rx_s_q;
          byte_err_d   = !rx_s_q;
          state_d      = R_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign rx_led     = (state_q != R_IDLE);
  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign byte_err   = byte_err_q;

endmodule

// File: rtl/hash_loader.sv
// Deframes a sync + 16-byte digest + XOR checksum sent over UART and loads it
// as the generator's compare target; partial or bad frames never touch it.
module hash_loader #(
  parameter int          CLKS_PER_BIT = hash_link_pkg::DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0]  SYNC_BYTE    = hash_link_pkg::SYNC_BYTE,
  parameter logic [23:0] TIMEOUT_CLKS = 24'd1200000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic         rx_led,
  output logic [0:127] target_hash,
  output logic         target_valid,
  output logic         hash_loaded,
  output logic         frame_err
);

  import hash_link_pkg::frame_state_t;
  import hash_link_pkg::F_IDLE;
  import hash_link_pkg::F_HASH;
  import hash_link_pkg::F_SUM;
  import hash_link_pkg::HASH_BYTES;

  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CLKS - 24'd1;
  localparam logic [3:0]  LAST_IDX     = 4'(HASH_BYTES - 1);

  logic [7:0]   byte_data;
  logic         byte_valid, byte_err;

  frame_state_t state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   sum_q, sum_d;
  logic [23:0]  timer_q, timer_d;
  logic [0:127] shadow_q, shadow_d;
  logic [0:127] target_hash_q, target_hash_d;
  logic         target_valid_q, target_valid_d;
  logic         hash_loaded_q, hash_loaded_d;
  logic         frame_err_q, frame_err_d;

  usart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_led    (rx_led),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= F_IDLE;
      idx_q          <= '0;
      sum_q          <= '0;
      timer_q        <= '0;
      shadow_q       <= '0;
      target_hash_q  <= '0;
      target_valid_q <= 1'b0;
      hash_loaded_q  <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      sum_q          <= sum_d;
      timer_q        <= timer_d;
      shadow_q       <= shadow_d;
      target_hash_q  <= target_hash_d;
      target_valid_q <= target_valid_d;
      hash_loaded_q  <= hash_loaded_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Inside a frame a byte error wins over a byte, which wins over the idle timeout,
  // so an aborted frame yields exactly one frame_err.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    sum_d          = sum_q;
    timer_d        = timer_q;
    shadow_d       = shadow_q;
    target_hash_d  = target_hash_q;
    target_valid_d = target_valid_q;
    hash_loaded_d  = 1'b0;
    frame_err_d    = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d  = F_HASH;
          idx_d    = '0;
          sum_d    = '0;
          timer_d  = '0;
          shadow_d = '0;
        end
      end
      F_HASH, F_SUM: begin
        if (byte_err) begin
          frame_err_d = 1'b1;
          state_d     = F_IDLE;
        end else if (byte_valid) begin
          timer_d = '0;
          if (state_q == F_HASH) begin
            shadow_d[8*idx_q +: 8] = byte_data;
            sum_d                  = sum_q ^ byte_data;
            idx_d                  = idx_q + 4'd1;
            if (idx_q == LAST_IDX) begin
              state_d = F_SUM;
            end
          end else begin
            state_d = F_IDLE;
            if (byte_data == sum_q) begin
              target_hash_d  = shadow_q;
              target_valid_d = 1'b1;
              hash_loaded_d  = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = F_IDLE;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  assign target_hash  = target_hash_q;
  assign target_valid = target_valid_q;
  assign hash_loaded  = hash_loaded_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_hash_loader.sv
// Directed frames over a bit-banged UART; expected load/error events go into a
// queue that a negedge monitor pops whenever the loader strobes an output.
module tb_hash_loader;

  localparam int          CPB  = 16;
  localparam logic [23:0] TO   = 24'd2000;
  localparam logic [127:0] GOOD = 128'haef656fe0f5a36d58ae1029630ba25e2;
  localparam logic [1:0]  EV_LOAD = 2'b10;
  localparam logic [1:0]  EV_ERR  = 2'b01;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx;
  logic         rx_led;
  logic [0:127] target_hash;
  logic         target_valid;
  logic         hash_loaded;
  logic         frame_err;

  typedef struct {
    logic [1:0]   kind;
    logic [127:0] hash;
    logic         valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;
  int   err_cycle = -1;
  int   last_byte_cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  hash_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_led      (rx_led),
    .target_hash (target_hash),
    .target_valid(target_valid),
    .hash_loaded (hash_loaded),
    .frame_err   (frame_err)
  );

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic expect_event(input logic [1:0] kind, input logic [127:0] hash, input logic valid);
    exp_t e;
    e.kind  = kind;
    e.hash  = hash;
    e.valid = valid;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    idle(4);
  endtask

  task automatic send_hash_bytes(input logic [127:0] h, input int first, input int count);
    for (int i = first; i < first + count; i++) send_byte(h[127-8*i -: 8], 1'b1);
  endtask

  task automatic apply_stimulus(input logic [127:0] h, input logic [7:0] cksum, input logic [1:0] kind,
                                input logic [127:0] exp_hash);
    send_byte(8'hA5, 1'b1);
    send_hash_bytes(h, 0, 16);
    expect_event(kind, exp_hash, 1'b1);
    send_byte(cksum, 1'b1);
    idle(40);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (hash_loaded || frame_err) begin
        if (frame_err) err_cycle = cycle;
        if (exp_q.size() == 0) begin
          check_output("unexpected_event", 128'({hash_loaded, frame_err}), 128'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("event_kind", 128'({hash_loaded, frame_err}), 128'(e.kind));
          check_output("target_hash", target_hash, e.hash);
          check_output("target_valid", 128'(target_valid), 128'(e.valid));
        end
      end
    end
  end

  initial begin
    int delay;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check_output("reset_rx_led", 128'(rx_led), 128'd0);
    check_output("reset_target_hash", target_hash, 128'd0);
    check_output("reset_target_valid", 128'(target_valid), 128'd0);
    check_output("reset_hash_loaded", 128'(hash_loaded), 128'd0);
    check_output("reset_frame_err", 128'(frame_err), 128'd0);
    reset = 1'b0;
    idle(10);

    $display("[TB] good frame");
    apply_stimulus(GOOD, 8'hF4, EV_LOAD, GOOD);

    $display("[TB] bad checksum");
    apply_stimulus(GOOD, 8'hF5, EV_ERR, GOOD);

    $display("[TB] noise before sync");
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    apply_stimulus(GOOD, 8'hF4, EV_LOAD, GOOD);

    $display("[TB] timeout");
    expect_event(EV_ERR, GOOD, 1'b1);
    err_cycle = -1;
    send_byte(8'hA5, 1'b1);
    send_hash_bytes(GOOD, 0, 5);
    last_byte_cycle = cycle;
    idle(2500);
    delay = err_cycle - last_byte_cycle;
    check_output("timeout_delay_in_window", 128'(delay >= 1950 && delay <= 2050), 128'd1);
    apply_stimulus(GOOD, 8'hF4, EV_LOAD, GOOD);

    $display("[TB] glitch mid-frame");
    send_byte(8'hA5, 1'b1);
    send_hash_bytes(GOOD, 0, 3);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check_output("glitch_rx_led_idle", 128'(rx_led), 128'd0);
    send_hash_bytes(GOOD, 3, 13);
    expect_event(EV_LOAD, GOOD, 1'b1);
    send_byte(8'hF4, 1'b1);
    idle(40);

    $display("[TB] bad stop bit mid-frame");
    send_byte(8'hA5, 1'b1);
    send_hash_bytes(GOOD, 0, 2);
    expect_event(EV_ERR, GOOD, 1'b1);
    send_byte(8'h5A, 1'b0);
    idle(60);

    $display("[TB] reset mid-frame");
    send_byte(8'hA5, 1'b1);
    send_hash_bytes(GOOD, 0, 8);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_output("midreset_target_hash", target_hash, 128'd0);
    check_output("midreset_target_valid", 128'(target_valid), 128'd0);
    check_output("midreset_rx_led", 128'(rx_led), 128'd0);
    check_output("midreset_strobes", 128'({hash_loaded, frame_err}), 128'd0);
    reset = 1'b0;
    idle(10);
    apply_stimulus(GOOD, 8'hF4, EV_LOAD, GOOD);

    check_output("events_outstanding", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
